// File: rtl/adc_pkt_tx_if.sv
// adc_pkt_tx_if
//   Bus bundle for the ADC packet transmitter: the capture-memory read port
//   and the packetised pad-side output.
//   master : transmitter side (drives read request and output word)
//   slave  : memory / pad side (returns read data, observes output word)
//   Signals:
//     mem_rd_en      read enable towards capture memory
//     mem_rd_addr    read address
//     mem_rd_data    read data, valid the cycle after mem_rd_en
//     adc_data       output word
//     adc_data_valid one cycle per output word
//     pkt_sof        first word of packet (with valid)
//     pkt_eof        last word of packet (with valid)
interface adc_pkt_tx_if #(
   parameter int DW = 18,
   parameter int AW = 12
);
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic [DW-1:0] adc_data;
   logic          adc_data_valid;
   logic          pkt_sof;
   logic          pkt_eof;

   modport master (
      output mem_rd_en, mem_rd_addr,
      input  mem_rd_data,
      output adc_data, adc_data_valid, pkt_sof, pkt_eof
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr,
      output mem_rd_data,
      input  adc_data, adc_data_valid, pkt_sof, pkt_eof
   );
endinterface

// File: rtl/adc_pkt_tx.sv
// adc_pkt_tx
//   Reads captured ADC samples out of the capture memory and emits them as
//   fixed-length packets with programmable word gap and inter-packet idle.
//   Self-test mode substitutes an incrementing counter for memory data.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start, again    one-cycle pulses that begin a run from address 0
//     self_test       1 = counter data, no memory reads
//     pkt_len_sel     packet length 216 << sel words
//     gap             idle cycles between words inside a packet
//     idle_len        extra idle cycles between packets
//     total_len       number of words in the run (0..2**AW)
//     bus             memory read port and packet output (master side)
//     busy            run in progress
//     done            one-cycle pulse when the run is complete
module adc_pkt_tx #(
   parameter int DW = 18,
   parameter int AW = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         again,
   input  logic         self_test,
   input  logic [1:0]   pkt_len_sel,
   input  logic [7:0]   gap,
   input  logic [7:0]   idle_len,
   input  logic [AW:0]  total_len,
   adc_pkt_tx_if.master bus,
   output logic         busy,
   output logic         done
);
   localparam int TW = AW + 1;

   typedef enum logic [2:0] {IDLE, FETCH, WORD, GAP, PKT_IDLE, DONE} state_t;

   state_t        state_q, state_d;
   logic          st_q;
   logic [1:0]    len_sel_q;
   logic [7:0]    gap_q, idle_q;
   logic [AW:0]   total_q;
   logic [AW-1:0] addr_q;
   logic [AW:0]   wcnt_q;
   logic [10:0]   ppos_q;
   logic [8:0]    wait_q, wait_d;
   logic          last_q, last_d;
   logic          issue, latch, is_last, is_eop;
   logic [10:0]   pkt_n;
   logic          vld_p1, sof_p1, eof_p1;
   logic [DW-1:0] stcnt_q, data_q;
   logic          vld_q, sof_q, eof_q;

   assign pkt_n   = 11'd216 << len_sel_q;
   assign is_last = (wcnt_q == total_q - TW'(1));
   assign is_eop  = (ppos_q == pkt_n - 11'd1);

   // An issue cycle is the read slot of one word; its output appears two
   // cycles later. The spacing rules are applied to issue cycles, so the
   // output inherits them exactly. The wait counter holds the number of
   // idle cycles still to spend in GAP/PKT_IDLE; after the final word the
   // same counter runs out the two-cycle pipeline before DONE.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      last_d  = last_q;
      issue   = 1'b0;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start || again) begin
               latch   = 1'b1;
               last_d  = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (total_q == '0) state_d = DONE;
            else               issue   = 1'b1;
         end
         WORD: issue = 1'b1;
         GAP, PKT_IDLE: begin
            wait_d = wait_q - 9'd1;
            if (wait_q == 9'd1) state_d = last_q ? DONE : WORD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (issue) begin
         if (is_last) begin
            state_d = GAP;
            wait_d  = 9'd2;
            last_d  = 1'b1;
         end else if (is_eop) begin
            wait_d  = {1'b0, idle_q} + {1'b0, gap_q};
            state_d = (wait_d == 9'd0) ? WORD : PKT_IDLE;
         end else begin
            wait_d  = {1'b0, gap_q};
            state_d = (gap_q == 8'd0) ? WORD : GAP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         last_q    <= 1'b0;
         st_q      <= 1'b0;
         len_sel_q <= '0;
         gap_q     <= '0;
         idle_q    <= '0;
         total_q   <= '0;
         addr_q    <= '0;
         wcnt_q    <= '0;
         ppos_q    <= '0;
         stcnt_q   <= '0;
         vld_p1    <= 1'b0;
         sof_p1    <= 1'b0;
         eof_p1    <= 1'b0;
         vld_q     <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         last_q  <= last_d;
         if (latch) begin
            st_q      <= self_test;
            len_sel_q <= pkt_len_sel;
            gap_q     <= gap;
            idle_q    <= idle_len;
            total_q   <= total_len;
            addr_q    <= '0;
            wcnt_q    <= '0;
            ppos_q    <= '0;
            stcnt_q   <= '0;
         end else if (issue) begin
            addr_q <= addr_q + AW'(1);
            wcnt_q <= wcnt_q + TW'(1);
            ppos_q <= is_eop ? 11'd0 : ppos_q + 11'd1;
         end
         // p1: memory read data is present on the bus this cycle
         vld_p1 <= issue;
         sof_p1 <= issue && (ppos_q == 11'd0);
         eof_p1 <= issue && (is_eop || is_last);
         // output register: word and framing flags presented to the pads
         vld_q <= vld_p1;
         sof_q <= sof_p1;
         eof_q <= eof_p1;
         if (vld_p1) begin
            data_q <= st_q ? stcnt_q : bus.mem_rd_data;
            if (st_q) stcnt_q <= stcnt_q + DW'(1);
         end
      end
   end

   assign bus.mem_rd_en      = issue && !st_q;
   assign bus.mem_rd_addr    = addr_q;
   assign bus.adc_data       = data_q;
   assign bus.adc_data_valid = vld_q;
   assign bus.pkt_sof        = sof_q;
   assign bus.pkt_eof        = eof_q;
   assign busy = (state_q == FETCH) || (state_q == WORD) ||
                 (state_q == GAP)   || (state_q == PKT_IDLE);
   assign done = (state_q == DONE);
endmodule

// File: tb/tb_adc_pkt_tx.sv
`timescale 1ns/1ps
module tb_adc_pkt_tx;
   localparam int DW = 18;
   localparam int AW = 12;
   localparam int TW = AW + 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, again = 1'b0, self_test = 1'b0;
   logic [1:0]    pkt_len_sel = '0;
   logic [7:0]    gap = '0, idle_len = '0;
   logic [AW:0]   total_len = '0;
   logic          busy, done;

   adc_pkt_tx_if #(.DW(DW), .AW(AW)) bus ();

   adc_pkt_tx #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .again(again), .self_test(self_test),
      .pkt_len_sel(pkt_len_sel), .gap(gap), .idle_len(idle_len), .total_len(total_len),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // capture memory: data returned the cycle after the read enable
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem[bus.mem_rd_addr];

   // observation queues
   int            v_cyc[$];
   logic [DW-1:0] v_dat[$];
   bit            v_sof[$], v_eof[$];
   int            rd_cyc[$], rd_addr[$], done_c[$];
   int            busy_cnt, stray_cnt, busy_done_cnt;

   always @(negedge clk) begin
      if (bus.adc_data_valid === 1'b1) begin
         v_cyc.push_back(cyc);
         v_dat.push_back(bus.adc_data);
         v_sof.push_back(bus.pkt_sof);
         v_eof.push_back(bus.pkt_eof);
      end else if (bus.pkt_sof === 1'b1 || bus.pkt_eof === 1'b1) begin
         stray_cnt++;
      end
      if (bus.mem_rd_en === 1'b1) begin
         rd_cyc.push_back(cyc);
         rd_addr.push_back(int'(bus.mem_rd_addr));
      end
      if (done === 1'b1) done_c.push_back(cyc);
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && done === 1'b1) busy_done_cnt++;
   end

   // reference model: expected output schedule from the packet rules
   int            e_cyc[$];
   logic [DW-1:0] e_dat[$];
   bit            e_sof[$], e_eof[$];
   int            e_done, e_nrd;

   int checks = 0;
   int errors = 0;

   task automatic build_model(input bit st, input int sel, input int g, input int idl,
                              input int tot, input int ts);
      int n;
      n = 216 << sel;
      e_cyc.delete(); e_dat.delete(); e_sof.delete(); e_eof.delete();
      for (int k = 0; k < tot; k++) begin
         e_cyc.push_back(ts + 3 + k * (g + 1) + (k / n) * idl);
         e_dat.push_back(st ? DW'(k) : mem[k]);
         e_sof.push_back((k % n) == 0);
         e_eof.push_back((k % n) == n - 1 || k == tot - 1);
      end
      e_done = (tot == 0) ? ts + 2 : e_cyc[e_cyc.size() - 1] + 1;
      e_nrd  = st ? 0 : tot;
   endtask

   task automatic score(output int bad_w, output int first, output int bad_rd);
      bad_w = 0; first = -1; bad_rd = 0;
      for (int k = 0; k < e_cyc.size() && k < v_cyc.size(); k++)
         if (v_cyc[k] != e_cyc[k] || v_dat[k] !== e_dat[k] ||
             v_sof[k] != e_sof[k] || v_eof[k] != e_eof[k]) begin
            bad_w++;
            if (first < 0) first = k;
         end
      for (int k = 0; k < rd_cyc.size() && k < e_cyc.size(); k++)
         if (rd_addr[k] != k || rd_cyc[k] != e_cyc[k] - 2) bad_rd++;
   endtask

   task automatic set_cfg(input bit st, input int sel, input int g, input int idl, input int tot);
      self_test   = st;
      pkt_len_sel = 2'(sel);
      gap         = 8'(g);
      idle_len    = 8'(idl);
      total_len   = TW'(tot);
   endtask

   task automatic clear_obs();
      v_cyc.delete(); v_dat.delete(); v_sof.delete(); v_eof.delete();
      rd_cyc.delete(); rd_addr.delete(); done_c.delete();
      busy_cnt = 0; stray_cnt = 0; busy_done_cnt = 0;
   endtask

   task automatic kick(input bit use_again, output int ts);
      @(posedge clk); #1;
      if (use_again) again = 1'b1; else start = 1'b1;
      ts = cyc;
      @(posedge clk); #1;
      start = 1'b0; again = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      int n;
      n = 0;
      while (done_c.size() == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      to = (done_c.size() == 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.adc_data_valid, bus.pkt_sof, bus.pkt_eof, bus.adc_data} !== '0) begin
         errors++;
         $display("FAIL reset_out valid=%b sof=%b eof=%b data=%h want all 0",
                  bus.adc_data_valid, bus.pkt_sof, bus.pkt_eof, bus.adc_data);
      end
      checks++;
      if ({busy, done, bus.mem_rd_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctl busy=%b done=%b rd_en=%b want 000", busy, done, bus.mem_rd_en);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_packet();
      int ts, bw, f, br; bit to;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      set_cfg(0, 0, 0, $urandom_range(0, 255), 216);
      clear_obs();
      kick(0, ts);
      build_model(0, 0, 0, int'(idle_len), 216, ts);
      wait_done(400, to);
      score(bw, f, br);
      checks++;
      if (to || v_cyc.size() != 216) begin
         errors++; $display("FAIL single_count got %0d want 216 timeout=%0b", v_cyc.size(), to);
      end
      checks++;
      if (v_cyc.size() == 0 || v_cyc[0] != ts + 3 || v_dat[0] !== '0 || !v_sof[0]) begin
         errors++; $display("FAIL single_first got %0d entries, want first valid at cycle %0d data 0 sof", v_cyc.size(), ts + 3);
      end
      checks++;
      if (bw != 0) begin
         errors++;
         $display("FAIL single_words bad=%0d first=%0d got cyc %0d data %h want cyc %0d data %h",
                  bw, f, v_cyc[f], v_dat[f], e_cyc[f], e_dat[f]);
      end
      checks++;
      if (done_c.size() != 1 || done_c[0] != ts + 219) begin
         errors++; $display("FAIL single_done count %0d got cyc %0d want %0d", done_c.size(),
                            (done_c.size() > 0) ? done_c[0] : -1, ts + 219);
      end
      checks++;
      if (rd_cyc.size() != 216 || br != 0) begin
         errors++; $display("FAIL single_reads got %0d reads (%0d bad) want 216", rd_cyc.size(), br);
      end
      checks++;
      if (busy_cnt != 218 || busy_done_cnt != 0) begin
         errors++; $display("FAIL single_busy got %0d busy cycles overlap %0d want 218 overlap 0", busy_cnt, busy_done_cnt);
      end
   endtask

   task automatic test_multi_packet();
      int ts, bw, f, br, nsof; bit to;
      randomize_mem();
      set_cfg(0, 3, 8, 15, 4096);
      clear_obs();
      kick(0, ts);
      build_model(0, 3, 8, 15, 4096, ts);
      wait_done(40000, to);
      score(bw, f, br);
      nsof = 0;
      foreach (v_sof[k]) if (v_sof[k]) nsof++;
      checks++;
      if (to || v_cyc.size() != 4096 || nsof != 3) begin
         errors++; $display("FAIL multi_count got %0d words %0d sof want 4096 words 3 sof", v_cyc.size(), nsof);
      end
      checks++;
      if (bw != 0) begin
         errors++;
         $display("FAIL multi_words bad=%0d first=%0d got cyc %0d data %h want cyc %0d data %h",
                  bw, f, v_cyc[f], v_dat[f], e_cyc[f], e_dat[f]);
      end
      checks++;
      if (v_cyc.size() < 1730 || v_cyc[1728] - v_cyc[1727] != 24 || v_cyc[1] - v_cyc[0] != 9) begin
         errors++; $display("FAIL multi_spacing eof-to-sof/word spacing wrong, want 24 and 9");
      end
      checks++;
      if (rd_cyc.size() != 4096 || br != 0) begin
         errors++; $display("FAIL multi_reads got %0d reads (%0d bad) want 4096", rd_cyc.size(), br);
      end
      checks++;
      if (done_c.size() != 1 || done_c[0] != e_done || stray_cnt != 0) begin
         errors++; $display("FAIL multi_done got %0d pulses stray %0d want 1 at %0d", done_c.size(), stray_cnt, e_done);
      end
   endtask

   task automatic test_self_test();
      int ts, bw, f, br, neof; bit to;
      set_cfg(1, 0, 0, 4, 300);
      clear_obs();
      kick(0, ts);
      build_model(1, 0, 0, 4, 300, ts);
      wait_done(600, to);
      score(bw, f, br);
      neof = 0;
      foreach (v_eof[k]) if (v_eof[k]) neof++;
      checks++;
      if (rd_cyc.size() != 0) begin
         errors++; $display("FAIL selftest_reads got %0d reads want 0", rd_cyc.size());
      end
      checks++;
      if (to || v_cyc.size() != 300 || bw != 0) begin
         errors++; $display("FAIL selftest_words got %0d words %0d bad want 300 / 0", v_cyc.size(), bw);
      end
      checks++;
      if (v_cyc.size() != 300 || neof != 2 || !v_eof[215] || !v_eof[299] || v_dat[299] !== DW'(299)) begin
         errors++; $display("FAIL selftest_eof got %0d eof want 2 at words 215 and 299", neof);
      end
   endtask

   task automatic test_zero_len();
      int ts; bit to;
      set_cfg(0, 1, 3, 3, 0);
      clear_obs();
      kick(0, ts);
      wait_done(20, to);
      checks++;
      if (to || done_c.size() != 1 || done_c[0] != ts + 2) begin
         errors++; $display("FAIL zero_done got %0d pulses at %0d want 1 at %0d", done_c.size(),
                            (done_c.size() > 0) ? done_c[0] : -1, ts + 2);
      end
      checks++;
      if (v_cyc.size() != 0 || rd_cyc.size() != 0) begin
         errors++; $display("FAIL zero_activity got %0d valid %0d reads want 0 0", v_cyc.size(), rd_cyc.size());
      end
   endtask

   task automatic test_ignore_restart();
      int ts, bw, f, br; bit to;
      randomize_mem();
      set_cfg(0, 1, 1, 5, 500);
      clear_obs();
      kick(0, ts);
      build_model(0, 1, 1, 5, 500, ts);
      repeat (300) @(posedge clk);
      #1;
      start = 1'b1; again = 1'b1;
      set_cfg(1, 0, 7, 0, 3);
      @(posedge clk); #1;
      start = 1'b0; again = 1'b0;
      wait_done(1500, to);
      score(bw, f, br);
      checks++;
      if (to || v_cyc.size() != 500 || bw != 0 || done_c.size() != 1) begin
         errors++; $display("FAIL ignore_words got %0d words %0d bad %0d done want 500 0 1",
                            v_cyc.size(), bw, done_c.size());
      end
      checks++;
      if (rd_cyc.size() != 500 || br != 0) begin
         errors++; $display("FAIL ignore_reads got %0d reads (%0d bad) want 500", rd_cyc.size(), br);
      end
   endtask

   task automatic test_again();
      int ts, bw, f, br, ndiff; bit to;
      logic [DW-1:0] prev[$];
      set_cfg(0, 2, 2, 3, 700);
      clear_obs();
      kick(0, ts);
      wait_done(3000, to);
      prev = v_dat;
      clear_obs();
      kick(1, ts);
      build_model(0, 2, 2, 3, 700, ts);
      wait_done(3000, to);
      score(bw, f, br);
      ndiff = 0;
      for (int k = 0; k < prev.size() && k < v_dat.size(); k++) if (prev[k] !== v_dat[k]) ndiff++;
      checks++;
      if (to || v_cyc.size() != 700 || bw != 0) begin
         errors++; $display("FAIL again_words got %0d words %0d bad want 700 0", v_cyc.size(), bw);
      end
      checks++;
      if (prev.size() != 700 || ndiff != 0 || rd_cyc.size() != 700 || br != 0) begin
         errors++; $display("FAIL again_repeat first run %0d words, %0d differ, %0d reads (%0d bad) want 700 0 700 0",
                            prev.size(), ndiff, rd_cyc.size(), br);
      end
   endtask

   task automatic test_reset_midrun();
      int ts, n, bw, f, br; bit to;
      randomize_mem();
      set_cfg(0, 1, 0, 2, 1000);
      clear_obs();
      kick(0, ts);
      n = 0;
      while (v_cyc.size() < 100 && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.adc_data_valid, busy, bus.mem_rd_en, done, bus.pkt_sof, bus.pkt_eof} !== 6'b0 || bus.adc_data !== '0) begin
         errors++; $display("FAIL rstmid_out valid=%b busy=%b rd_en=%b done=%b data=%h want all 0",
                            bus.adc_data_valid, busy, bus.mem_rd_en, done, bus.adc_data);
      end
      rst = 1'b0;
      clear_obs();
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (done_c.size() != 0 || v_cyc.size() != 0 || rd_cyc.size() != 0) begin
         errors++; $display("FAIL rstmid_quiet got %0d done %0d valid %0d reads want 0", done_c.size(), v_cyc.size(), rd_cyc.size());
      end
      set_cfg(0, 0, 1, 1, 50);
      clear_obs();
      kick(0, ts);
      build_model(0, 0, 1, 1, 50, ts);
      wait_done(300, to);
      score(bw, f, br);
      checks++;
      if (to || v_cyc.size() != 50 || v_dat[0] !== mem[0] || bw != 0 || br != 0) begin
         errors++; $display("FAIL rstmid_restart got %0d words first %h want 50 first %h", v_cyc.size(),
                            (v_dat.size() > 0) ? v_dat[0] : '0, mem[0]);
      end
   endtask

   task automatic test_random_cfg();
      int ts, bw, f, br, sel, g, idl, tot; bit st, to;
      for (int it = 0; it < 3; it++) begin
         randomize_mem();
         st = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 3); g = $urandom_range(0, 3);
         idl = $urandom_range(0, 20); tot = $urandom_range(1, 900);
         set_cfg(st, sel, g, idl, tot);
         clear_obs();
         kick(0, ts);
         build_model(st, sel, g, idl, tot, ts);
         wait_done(tot * (g + 1) + (tot / 216 + 1) * idl + 50, to);
         score(bw, f, br);
         checks++;
         if (to || v_cyc.size() != tot || bw != 0 || rd_cyc.size() != e_nrd || br != 0 ||
             done_c.size() != 1 || done_c[0] != e_done) begin
            errors++;
            $display("FAIL random_run%0d st=%0b sel=%0d gap=%0d idle=%0d tot=%0d got %0d words %0d bad %0d reads want %0d 0 %0d",
                     it, st, sel, g, idl, tot, v_cyc.size(), bw, rd_cyc.size(), tot, e_nrd);
         end
      end
   endtask

   initial begin
      randomize_mem();
      test_reset();
      test_single_packet();
      test_multi_packet();
      test_self_test();
      test_zero_len();
      test_ignore_restart();
      test_again();
      test_reset_midrun();
      test_random_cfg();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
